// File: rtl/term_stream_encoder.sv
// term_stream_encoder: splits each operand into MSB-first power-of-two terms under a term budget.
// Optional macro TERM_STREAM_SIGNED_EN: two's-complement operands, magnitude streamed with a term_sign port.
module term_stream_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_TERMS  = 3,
    parameter int EXP_WIDTH  = $clog2(DATA_WIDTH),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  term_valid,
    input  logic                  term_ready,
    output logic [EXP_WIDTH-1:0]  term_exp,
    output logic                  term_zero,
    output logic                  term_last,
    output logic                  term_trunc,
`ifdef TERM_STREAM_SIGNED_EN
    output logic                  term_sign,
`endif
    output logic [CNT_WIDTH-1:0]  trunc_count
);
    localparam int TW = $clog2(MAX_TERMS + 1);
    localparam logic [TW-1:0] LAST_TERM = TW'(MAX_TERMS - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_res;
    logic [TW-1:0]         r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_mag;
    logic [EXP_WIDTH-1:0]  w_exp;
    logic                  w_emit;
    logic                  w_budget;
    logic                  w_accept;
    logic                  w_fire;

`ifdef TERM_STREAM_SIGNED_EN
    assign w_mag = in_data[DATA_WIDTH-1] ? -in_data : in_data;
`else
    assign w_mag = in_data;
`endif

    // Locate the highest set residual bit and form the residual with it removed
    always_comb begin
        w_exp = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (r_res[i]) w_exp = EXP_WIDTH'(i);
        w_clr = r_res;
        w_clr[w_exp] = 1'b0;
    end

    assign w_emit     = r_state == EMIT;
    assign w_budget   = r_cnt == LAST_TERM;
    assign w_accept   = r_state == IDLE && in_valid && r_ready;
    assign w_fire     = w_emit && term_ready;
    assign in_ready   = r_ready;
    assign term_valid = w_emit;
    assign term_exp   = w_emit ? w_exp : '0;
    assign term_zero  = w_emit && r_res == '0;
    assign term_last  = w_emit && (w_clr == '0 || w_budget);
    assign term_trunc = w_emit && w_budget && w_clr != '0;

    // Operand capture, per-beat residual/counter update and truncation tally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_res       <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            trunc_count <= '0;
        end else begin
            r_ready <= !w_emit;
            if (w_accept) begin
                r_state <= EMIT;
                r_res   <= w_mag;
                r_cnt   <= '0;
                r_ready <= 1'b0;
            end else if (w_fire) begin
                r_res <= w_clr;
                r_cnt <= r_cnt + 1'b1;
                if (term_last) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    if (term_trunc && !(&trunc_count)) trunc_count <= trunc_count + 1'b1;
                end
            end
        end
    end

`ifdef TERM_STREAM_SIGNED_EN
    // Sign is latched at accept and held across all beats of the operand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) term_sign <= 1'b0;
        else if (w_accept) term_sign <= in_data[DATA_WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_term_stream_encoder.sv
// tb_term_stream_encoder: randomized scoreboard bench for term_stream_encoder.
module tb_term_stream_encoder;
    localparam int DW = 8;
    localparam int MT = 3;
    localparam int EW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          term_valid;
    logic          term_ready;
    logic [EW-1:0] term_exp;
    logic          term_zero;
    logic          term_last;
    logic          term_trunc;
    logic [CW-1:0] trunc_count;
    logic          tb_sign;

    term_stream_encoder #(.DATA_WIDTH(DW), .MAX_TERMS(MT), .EXP_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .term_valid(term_valid), .term_ready(term_ready), .term_exp(term_exp),
        .term_zero(term_zero), .term_last(term_last), .term_trunc(term_trunc),
`ifdef TERM_STREAM_SIGNED_EN
        .term_sign(tb_sign),
`endif
        .trunc_count(trunc_count)
    );
`ifndef TERM_STREAM_SIGNED_EN
    assign tb_sign = 1'b0;
`endif

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] q[$];
    int          exp_tc = 0;
    bit          exp_ready_chk = 0;
    bit          rand_mode = 0;
    int          hold_low = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    function automatic logic [15:0] pack(input logic s, input logic z, input logic l, input logic t, input logic [EW-1:0] e);
        return {4'b0, s, z, l, t, 5'b0, e};
    endfunction

    // Reference: list the set bits of the magnitude from the top, stop at the budget
    function automatic void model(input logic [DW-1:0] d);
        logic [DW-1:0] m;
        logic s;
        int n;
        s = 1'b0;
        m = d;
        n = 0;
`ifdef TERM_STREAM_SIGNED_EN
        if (d[DW-1]) begin s = 1'b1; m = -d; end
`endif
        if (m == 0) begin
            q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, '0));
            return;
        end
        for (int b = DW - 1; b >= 0; b--) begin
            if (m[b]) begin
                bit l, t;
                m[b] = 1'b0;
                n++;
                l = (m == 0) || (n == MT);
                t = (n == MT) && (m != 0);
                q.push_back(pack(s, 1'b0, l, t, EW'(b)));
                if (l) break;
            end
        end
    endfunction

    task automatic send(input logic [DW-1:0] d, input bit stall);
        int w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            in_valid = 1'($urandom);
            in_data = DW'($urandom);
            if (++w > 200) begin
                chk("in_ready_timeout", {31'b0, in_ready}, 1);
                in_valid = 1'b0;
                return;
            end
        end
        chk("trunc_count", trunc_count, exp_tc);
        in_valid = 1'b1;
        in_data = d;
        if (stall) hold_low = 3;
        model(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = DW'($urandom);
    endtask

    // Downstream ready: directed low stretch, random, or always ready
    initial begin
        term_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low > 0) begin
                term_ready = 1'b0;
                hold_low--;
            end else term_ready = rand_mode ? ($urandom % 4 != 0) : 1'b1;
        end
    end

    // Monitor: pops expected beats, checks hold under backpressure and ready after last
    initial begin
        logic [15:0] prev, cur, e;
        bit prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) prev_stall = 0;
            else begin
                cur = pack(tb_sign, term_zero, term_last, term_trunc, term_exp);
                if (exp_ready_chk) begin
                    chk("in_ready_after_last", {31'b0, in_ready}, 1);
                    exp_ready_chk = 0;
                end
                if (prev_stall) chk("stall_hold", {15'b0, term_valid, cur}, {15'b0, 1'b1, prev});
                if (term_valid) begin
                    if (term_ready) begin
                        if (q.size() == 0) chk("unexpected_beat", {16'b0, cur}, 32'hFFFF_FFFF);
                        else begin
                            e = q.pop_front();
                            chk("beat", {16'b0, cur}, {16'b0, e});
                            if (e[9]) exp_ready_chk = 1;
                            if (e[8] && exp_tc < 65535) exp_tc++;
                        end
                    end
                    prev_stall = !term_ready;
                    prev = cur;
                end else prev_stall = 0;
            end
        end
    end

    initial begin
        int w;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_term_valid", {31'b0, term_valid}, 0);
        chk("rst_outs", {28'b0, term_zero, term_last, term_trunc, 1'b0} | {29'b0, term_exp}, 0);
        chk("rst_trunc_count", {16'b0, trunc_count}, 0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("ready_after_rst", {31'b0, in_ready}, 1);

        send(8'hB5, 0);
        send(8'h12, 0);
        send(8'h00, 0);
        send(8'h81, 1);
        send(8'hFF, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_term_valid", {31'b0, term_valid}, 0);
        chk("midrst_in_ready", {31'b0, in_ready}, 0);
        chk("midrst_trunc_count", {16'b0, trunc_count}, 0);
        q.delete();
        exp_tc = 0;
        exp_ready_chk = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("ready_after_midrst", {31'b0, in_ready}, 1);
        send(8'h03, 0);
        send(8'hFA, 0);
        send(8'h80, 0);

        rand_mode = 1;
        for (int k = 0; k < 250; k++) begin
            logic [DW-1:0] d;
            case ($urandom % 4)
                0: d = '0;
                1: d = DW'(1) << ($urandom % DW);
                default: d = DW'($urandom);
            endcase
            send(d, ($urandom % 8) == 0);
        end

        w = 0;
        while ((q.size() != 0 || !in_ready) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue", q.size(), 0);
        @(negedge clk);
        chk("final_trunc_count", {16'b0, trunc_count}, exp_tc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
